atan_poly_quadrant: RTL

ATAN_POLY_QUADRANT -- requirements
Module: atan_poly_quadrant

---
 rtl/atan_poly_quadrant.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/atan_poly_quadrant.sv
// -----------------------------------------------------------------------------
// atan_poly_quadrant
//
// Final stage of the CORDIC-free phase estimator. A pre-divided octant ratio
// (min/max of |re|,|im| in Q1.7) is turned into a 10-bit phase using a
// second-order polynomial correction. The octant code then folds the result
// into the full circle.
//
//   a     = r + round(ATAN_C * r * (128 - r) / 2^15)   (128 == pi/4)
//   angle = base(flag) +/- a  (mod 1024, 1024 == 2*pi)
//
// Fixed 4-cycle pipeline with one sample per cycle and no backpressure.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset (clears every register)
//   val_i         input sample valid
//   ratio_i       Q1.7 unsigned ratio; values above 128 are clamped
//   case_flag_i   octant code aligned with ratio_i
//   angle_o       phase, 1024 == 2*pi; holds while val_o is low
//   val_o         angle_o valid, val_i delayed by 4 cycles
//   sample_cnt_o  number of val_o pulses since reset, saturating at 65535
// -----------------------------------------------------------------------------
module atan_poly_quadrant #(
  parameter int ATAN_C = 89,
  parameter int LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        val_i,
  input  logic [7:0]  ratio_i,
  input  logic [2:0]  case_flag_i,
  output logic [9:0]  angle_o,
  output logic        val_o,
  output logic [15:0] sample_cnt_o
);

  // The pipeline depth is structural; LAT only documents it.
  if (LAT != 4) begin : g_lat_guard
    $error("atan_poly_quadrant: LAT must be 4");
  end

  logic       vld_p1, vld_p2, vld_p3;
  logic [7:0] r_p1, d_p1, r_p2, a_p3;
  logic [2:0] flag_p1, flag_p2, flag_p3;
  logic [13:0] p_p2;

  // Divider results above 1.0 are out of range; treat them as exactly 1.0.
  function automatic logic [7:0] clamp_ratio(input logic [7:0] x);
    return (x > 8'd128) ? 8'd128 : x;
  endfunction

  // Round-half-up of ATAN_C * p / 2^15. Largest value is 11, so 8 bits suffice.
  function automatic logic [7:0] round_corr(input logic [13:0] p);
    logic [23:0] acc;
    acc = 24'(ATAN_C) * {10'd0, p} + 24'd16384;
    return 8'(acc >> 15);
  endfunction

  // Fold the octant angle into the full circle using 11-bit signed math;
  // dropping the top bit gives the modulo-1024 wrap.
  function automatic logic [9:0] fold_octant(input logic [2:0] flag,
                                             input logic [7:0] a);
    logic signed [10:0] base;
    logic signed [10:0] mag;
    logic               neg;
    base = 11'sd0;
    neg  = 1'b0;
    mag  = signed'({3'b000, a});
    case (flag)
      3'd0: begin base = -11'sd512; neg = 1'b0; end
      3'd1: begin base =  11'sd0;   neg = 1'b0; end
      3'd2: begin base =  11'sd512; neg = 1'b1; end
      3'd3: begin base =  11'sd0;   neg = 1'b1; end
      3'd4: begin base = -11'sd256; neg = 1'b1; end
      3'd5: begin base =  11'sd256; neg = 1'b1; end
      3'd6: begin base =  11'sd256; neg = 1'b0; end
      3'd7: begin base = -11'sd256; neg = 1'b0; end
      default: begin base = 11'sd0; neg = 1'b0; end
    endcase
    return 10'(neg ? (base - mag) : (base + mag));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Stage 1: clamp the ratio and form its complement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      r_p1    <= '0;
      d_p1    <= '0;
      flag_p1 <= '0;
    end else begin
      vld_p1  <= val_i;
      r_p1    <= clamp_ratio(ratio_i);
      d_p1    <= 8'd128 - clamp_ratio(ratio_i);
      flag_p1 <= case_flag_i;
    end
  end

  // Stage 2: product r*(128-r), peak 4096 at r = 64
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      r_p2    <= '0;
      p_p2    <= '0;
      flag_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      r_p2    <= r_p1;
      p_p2    <= {6'd0, r_p1} * {6'd0, d_p1};
      flag_p2 <= flag_p1;
    end
  end

  // Stage 3: polynomial-corrected octant angle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      a_p3    <= '0;
      flag_p3 <= '0;
    end else begin
      vld_p3  <= vld_p2;
      a_p3    <= r_p2 + round_corr(p_p2);
      flag_p3 <= flag_p2;
    end
  end

  // Stage 4: octant fold; output holds between valid samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_o        <= 1'b0;
      angle_o      <= '0;
      sample_cnt_o <= '0;
    end else begin
      val_o <= vld_p3;
      if (vld_p3) begin
        angle_o <= fold_octant(flag_p3, a_p3);
      end
      if (val_o) begin
        sample_cnt_o <= sat_inc(sample_cnt_o);
      end
    end
  end

endmodule
